// File: rtl/cpu_defs.sv
// Shared definitions for the control sequencer: field layout, state encoding and opcodes.
package cpu_defs;

    localparam int unsigned IRW    = 32;
    localparam int unsigned OPW    = 5;
    localparam int unsigned RFW    = 4;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_LSB = 15;

    // RESET_ST .. HALT, one T-step per state
    typedef enum logic [3:0] {
        StReset   = 4'd0,
        StFetch0  = 4'd1,
        StFetch1  = 4'd2,
        StFetch2  = 4'd3,
        StExec3   = 4'd4,
        StExec4   = 4'd5,
        StExec5   = 4'd6,
        StExec6   = 4'd7,
        StStopped = 4'd8,
        StHalt    = 4'd9
    } state_e;

    localparam logic [OPW-1:0] OpNop  = 5'b00000;
    localparam logic [OPW-1:0] OpAdd  = 5'b00011;
    localparam logic [OPW-1:0] OpSub  = 5'b00100;
    localparam logic [OPW-1:0] OpAnd  = 5'b00101;
    localparam logic [OPW-1:0] OpOr   = 5'b00110;
    localparam logic [OPW-1:0] OpMul  = 5'b01111;
    localparam logic [OPW-1:0] OpDiv  = 5'b10000;
    localparam logic [OPW-1:0] OpHalt = 5'b11011;

endpackage

// File: rtl/opcode_decoder.sv
// Classifies the IR opcode field into the instruction groups the sequencer branches on.
module opcode_decoder
    import cpu_defs::*;
(
    input  logic [OPW-1:0] opcode_i,
    output logic           is_alu_o,
    output logic           is_muldiv_o,
    output logic           is_nop_o,
    output logic           is_halt_o,
    output logic           is_illegal_o
);

    // Exactly one class flag is raised for every opcode value
    always_comb begin
        is_alu_o     = 1'b0;
        is_muldiv_o  = 1'b0;
        is_nop_o     = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OpAdd, OpSub, OpAnd, OpOr: is_alu_o    = 1'b1;
            OpMul, OpDiv:              is_muldiv_o = 1'b1;
            OpNop:                     is_nop_o    = 1'b1;
            OpHalt:                    is_halt_o   = 1'b1;
            default:                   is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit stepping the single-bus datapath through fetch and execute T-steps.
module control_sequencer
    import cpu_defs::*;
(
    input  logic           Clock,
    input  logic           Reset,
    input  logic [IRW-1:0] IR,
    input  logic           mem_ready,
    input  logic           Stop,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           Zin,
    output logic           ZLOout,
    output logic           ZHIout,
    output logic           PCin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] alu_op,
    output logic           Run,
    output logic           illegal
);

    state_e         state_q, state_d;
    state_e         boundary_next;
    logic [OPW-1:0] opcode;
    logic           is_alu, is_muldiv, is_nop, is_halt, is_illegal;
    logic           unused_ir;

    assign opcode = IR[OP_LSB +: OPW];

    // Register fields are routed by Gra/Grb/Grc in the datapath, not decoded here
    assign unused_ir = ^{IR[RA_LSB +: RFW], IR[RB_LSB +: RFW], IR[RC_LSB +: RFW],
                         IR[RC_LSB-1:0]};

    opcode_decoder u_opcode_decoder (
        .opcode_i     (opcode),
        .is_alu_o     (is_alu),
        .is_muldiv_o  (is_muldiv),
        .is_nop_o     (is_nop),
        .is_halt_o    (is_halt),
        .is_illegal_o (is_illegal)
    );

    // Stop is only honoured at an instruction boundary
    assign boundary_next = Stop ? StStopped : StFetch0;

    // State register, asynchronously forced to reset state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset:   state_d = boundary_next;
            StFetch0:  state_d = StFetch1;
            StFetch1:  state_d = mem_ready ? StFetch2 : StFetch1;
            StFetch2:  state_d = StExec3;
            StExec3: begin
                if (is_alu || is_muldiv) begin
                    state_d = StExec4;
                end else if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = boundary_next;
                end
            end
            StExec4:   state_d = StExec5;
            StExec5:   state_d = is_muldiv ? StExec6 : boundary_next;
            StExec6:   state_d = boundary_next;
            StStopped: state_d = Stop ? StStopped : StFetch0;
            StHalt:    state_d = StHalt;
            default:   state_d = StReset;
        endcase
    end

    // Strobe decode from registered state and the datapath's IR
    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Zin     = 1'b0;
        ZLOout  = 1'b0;
        ZHIout  = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        HIin    = 1'b0;
        LOin    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        alu_op  = '0;
        Run     = 1'b1;
        illegal = 1'b0;
        case (state_q)
            StFetch0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            StFetch1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            StFetch2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StExec3: begin
                if (is_alu || is_muldiv) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
                illegal = is_illegal;
            end
            StExec4: begin
                Grc    = 1'b1;
                Rout   = 1'b1;
                Zin    = 1'b1;
                alu_op = opcode;
            end
            StExec5: begin
                ZLOout = 1'b1;
                if (is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            StExec6: begin
                ZHIout = 1'b1;
                HIin   = 1'b1;
            end
            default: Run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed scenarios plus random instructions against a T-step table model.
module tb_control_sequencer;

    typedef struct packed {
        logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin;
        logic Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout, Run, illegal;
        logic [4:0] alu_op;
    } outs_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] IR;
    logic        mem_ready;
    logic        Stop;
    logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout, Run, illegal;
    logic [4:0] alu_op;
    outs_t      obs;
    int         total = 0;
    int         bad = 0;
    localparam outs_t IDLE = '0;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .mem_ready(mem_ready), .Stop(Stop),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .ZLOout(ZLOout),
        .ZHIout(ZHIout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run), .illegal(illegal)
    );

    assign obs = {PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin,
                  Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout, Run, illegal, alu_op};

    always #5 Clock = ~Clock;

    // Instruction class from the opcode table: 0 nop, 1 halt, 2 alu, 3 mul/div, 4 illegal
    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'b00000: return 0;
            5'b11011: return 1;
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return 2;
            5'b01111, 5'b10000: return 3;
            default: return 4;
        endcase
    endfunction

    // Expected strobes for T-step t of an instruction with opcode op
    function automatic outs_t pat(input int t, input logic [4:0] op);
        outs_t e;
        int    c;
        e = '0;
        c = op_class(op);
        e.Run = 1'b1;
        case (t)
            0: begin e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; end
            1: begin e.ZLOout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1; end
            2: begin e.MDRout = 1; e.IRin = 1; end
            3: begin
                if (c == 2 || c == 3) begin e.Grb = 1; e.Rout = 1; e.Yin = 1; end
                if (c == 4) e.illegal = 1;
            end
            4: begin e.Grc = 1; e.Rout = 1; e.Zin = 1; e.alu_op = op; end
            5: begin
                e.ZLOout = 1;
                if (c == 3) e.LOin = 1;
                else begin e.Gra = 1; e.Rin = 1; end
            end
            6: begin e.ZHIout = 1; e.HIin = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input outs_t exp, input string tag);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run one instruction from FETCH0; Stop rises at step stop_at, Reset fires after step reset_at
    task automatic run_instr(input logic [31:0] ir, input int waits, input int stop_at,
                             input int reset_at, input string tag);
        outs_t      q[$];
        logic [4:0] op;
        int         c;
        op = ir[31:27];
        c = op_class(op);
        Stop = 1'b0;
        IR = $urandom;
        q.push_back(pat(0, op));
        for (int w = 0; w <= waits; w++) q.push_back(pat(1, op));
        q.push_back(pat(2, op));
        q.push_back(pat(3, op));
        if (c == 2 || c == 3) begin
            q.push_back(pat(4, op));
            q.push_back(pat(5, op));
        end
        if (c == 3) q.push_back(pat(6, op));
        for (int i = 0; i < q.size(); i++) begin
            if (i >= stop_at) Stop = 1'b1;
            check(q[i], $sformatf("%s_step%0d", tag, i));
            if (i == reset_at) begin
                #1 Reset = 1'b1;
                #1 check(IDLE, {tag, "_async_reset"});
                return;
            end
            if (i >= 1 && i <= waits + 1) mem_ready = (i == waits + 1);
            else mem_ready = 1'($urandom);
            if (i == waits + 2) IR = ir;
            @(posedge Clock);
            #1;
        end
    endtask

    logic [4:0] valid_ops [7] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                  5'b01111, 5'b10000, 5'b00000};

    initial begin
        logic [4:0] op;
        Reset = 1'b1;
        IR = 32'h0;
        mem_ready = 1'b0;
        Stop = 1'b0;
        repeat (2) @(posedge Clock);
        #1 check(IDLE, "reset_state");
        @(negedge Clock) Reset = 1'b0;
        @(posedge Clock);
        #1;

        // add R5,R2,R3 without wait states
        run_instr(32'h1A918000, 0, 99, 99, "add");
        // div with three memory wait cycles
        run_instr(32'h80918000, 3, 99, 99, "div_wait3");
        // undefined opcode 11111
        run_instr({5'b11111, 27'h0123456}, 1, 99, 99, "illegal");

        // Stop raised in EXEC4: instruction finishes, then pauses without touching PC
        run_instr(32'h1A918000, 0, 4, 99, "add_stop");
        for (int k = 0; k < 3; k++) begin
            check(IDLE, $sformatf("stopped_%0d", k));
            @(posedge Clock);
            #1;
        end
        Stop = 1'b0;
        @(posedge Clock);
        #1;

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            int stop_at;
            if ($urandom_range(0, 2) == 0) op = valid_ops[$urandom_range(0, 6)];
            else op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b00000;
            stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 99;
            run_instr({op, 27'($urandom)}, int'($urandom_range(0, 3)), stop_at, 99,
                      $sformatf("rand%0d", n));
            if (Stop) begin
                repeat ($urandom_range(1, 3)) begin
                    check(IDLE, $sformatf("rand%0d_stopped", n));
                    @(posedge Clock);
                    #1;
                end
                Stop = 1'b0;
                @(posedge Clock);
                #1;
            end
        end

        // Reset in the middle of EXEC4 drops every strobe without a clock edge
        run_instr(32'h1A918000, 0, 99, 4, "add_rst");
        @(posedge Clock);
        #1 check(IDLE, "reset_held");
        @(negedge Clock) Reset = 1'b0;
        @(posedge Clock);
        #1;
        run_instr(32'h1A918000, 2, 99, 99, "add_after_rst");

        // halt: parks until Reset, Stop has no effect
        run_instr(32'hD8000000, 0, 99, 99, "halt");
        for (int k = 0; k < 6; k++) begin
            Stop = 1'($urandom);
            mem_ready = 1'($urandom);
            check(IDLE, $sformatf("halted_%0d", k));
            @(posedge Clock);
            #1;
        end
        Stop = 1'b0;
        check(IDLE, "halted_stop_low");
        @(posedge Clock);
        #1 check(IDLE, "halted_stays");
        Reset = 1'b1;
        @(negedge Clock) Reset = 1'b0;
        @(posedge Clock);
        #1;
        run_instr(32'h7A918000, 0, 99, 99, "mul_after_halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore-style control unit that sequences the single-bus datapath through instruction fetch and execute.
- Drives every register-enable, bus-select and ALU-select strobe that the datapath test benches previously generated by hand, one T-step per clock.
- Covers fetch, R-format ALU ops, mul/div (HI/LO write-back), nop and halt, plus a memory-ready wait and an external Stop.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- RFW, 4, register-field width (Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]).

Ports:
- Clock  in  1  system clock, all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; forces state RESET_ST.
- IR  in  32  instruction register contents from datapath.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- Stop  in  1  level request to pause at the next instruction boundary.
- PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- Gra, Grb, Grc  out  1 each  select-and-encode field selects.
- Rin, Rout  out  1 each  register-file write / bus-drive via selected field.
- alu_op  out  5  ALU operation code (opcode pass-through, 0 when idle).
- Run  out  1  high while executing, low in STOPPED/HALT.
- illegal  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Outputs decoded purely from registered state and latched IR; no input-to-output combinational path except none. Datapath registers capture on the edge that ends the state.
- Reset (any time, including mid-instruction): state=RESET_ST, all strobes 0, alu_op=0, Run=0, illegal=0. First clock after Reset deasserts -> FETCH0.
- FETCH0 (T0): PCout, MARin, IncPC, Zin. Run=1. If Stop=1 on entry edge, go STOPPED instead (sampled on the transition out of EXEC-final/FETCH2-nop/RESET_ST).
- FETCH1 (T1): ZLOout, PCin, Read, MDRin. Hold in FETCH1 while mem_ready=0 (strobes stay asserted; re-latching PC from unchanged Z is harmless). mem_ready=1 -> FETCH2.
- FETCH2 (T2): MDRout, IRin. Next state decoded from IR opcode on the following edge (IR is valid in EXEC3 onward).
- EXEC3 (T3): decode. ALU/mul/div: Grb, Rout, Yin. nop (00000): -> FETCH0. halt (11011): -> HALT. Undefined: illegal=1 for this cycle, no strobes, -> FETCH0.
- EXEC4 (T4): Grc, Rout, Zin, alu_op=opcode.
- EXEC5 (T5): ALU ops: ZLOout, Gra, Rin -> FETCH0. mul/div: ZLOout, LOin -> EXEC6.
- EXEC6 (T6): ZHIout, HIin -> FETCH0.
- STOPPED: all strobes 0, Run=0; leaves to FETCH0 when Stop=0. PC not advanced.
- HALT: all strobes 0, Run=0; exits only via Reset. Stop ignored.
- Opcodes: add 00011, sub 00100, and 00101, or 00110, mul 01111, div 10000, nop 00000, halt 11011; all else illegal.
- At most one bus driver (Rout, PCout, MDRout, ZLOout, ZHIout) asserted in any state — invariant.
- Latency: ALU op 6 cycles, mul/div 7 cycles (no wait states); each mem_ready=0 cycle adds one.

Decomposition:
- Shared package cpu_defs: state encoding constants (RESET_ST..HALT, 4 bits), opcode constants, field bit positions.
- One sub-module: opcode_decoder (combinational, IR[31:27] -> is_alu, is_muldiv, is_nop, is_halt, is_illegal). Sequencer holds state register and output decode.

Test Plan:
- Reset mid-EXEC4 (Zin, Grc high) -> all strobes drop 0 asynchronously without a clock edge; after release, FETCH0 on next edge with PCout=MARin=IncPC=Zin=1.
- IR=0x1A918000 (add R5,R2,R3), mem_ready=1 -> strobe sequence T0..T5 as specified, alu_op=00011 only in T4, Gra+Rin in T5, back to FETCH0 at cycle 7.
- IR=0x80918000 (div), mem_ready low 3 cycles in T1 -> FETCH1 held 4 cycles, then T4 alu_op=10000, T5 ZLOout+LOin, T6 ZHIout+HIin; total 10 cycles.
- IR opcode 11111 -> illegal pulses exactly one cycle in EXEC3, no Rin/HIin/LOin ever asserted, returns to FETCH0.
- Stop raised during EXEC4 of add -> instruction completes (Rin in T5), then STOPPED with Run=0; Stop low -> FETCH0 next edge, PC unchanged meanwhile (no IncPC).
- IR=0xD8000000 (halt) -> HALT, Run=0, Stop toggling has no effect; only Reset recovers.
